sub_e: RTL and testbench

SUB_E -- requirements
Module: sub_e

---
 rtl/sub_e.sv | 143 ++++++++++++++
 tb/tb_sub_e.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sub_e.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sub_e : 2-bit symbol to byte assembler with framing check and byte FIFO     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module sub_e #(
  parameter int FIFO_DEPTH   = 4,
  parameter int SYM_PER_BYTE = 4
) (
  input  logic                                testi_clk_e,
  input  logic                                testi_rst_n_e,
  input  logic                                testi1_e,
  input  logic [1:0]                          testi2_e,
  input  logic                                testi3_e,
  input  logic                                testi4_e,
  input  logic                                testi5_e,
  output logic                                testo1_e,
  output logic [7:0]                          testo2_e,
  output logic                                testo3_e,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     testo4_e,
  output logic                                testo5_e
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_ASSEMBLE = 1'b1;

  localparam logic [1:0]       LAST_SYM = 2'(SYM_PER_BYTE - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  logic             r_run;
  logic [0:0]       r_state;
  logic [1:0]       r_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [LVL_W-1:0] r_level;
  logic             r_ferr;
  logic             r_ovf;

  logic             w_sym;
  logic             w_frm_err;
  logic             w_push;
  logic [7:0]       w_push_byte;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;
  logic             w_ovf;

  // Reset release is retimed by one flop, so the core leaves reset on the first
  // edge after deassertion and can accept a symbol on the second.
  always_ff @(posedge testi_clk_e or negedge testi_rst_n_e) begin
    if (!testi_rst_n_e) r_run <= 1'b0;
    else                r_run <= 1'b1;
  end

  always_comb begin
    w_sym       = testi1_e & r_run;
    w_frm_err   = w_sym & (((r_state == S_IDLE) & ~testi3_e) |
                           ((r_state == S_ASSEMBLE) & testi3_e));
    w_push      = w_sym & (r_state == S_ASSEMBLE) & ~testi3_e & (r_cnt == LAST_SYM);
    w_push_byte = {testi2_e, r_shift[5:0]};
    w_empty     = (r_level == '0);
    w_full      = (r_level == LVL_FULL);
    w_pop       = ~w_empty & testi4_e;
    w_wr        = w_push & (~w_full | w_pop);
    w_ovf       = w_push & w_full & ~w_pop;
  end

  always_ff @(posedge testi_clk_e or negedge testi_rst_n_e) begin
    if (!testi_rst_n_e) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_shift <= 8'h00;
    end else if (!r_run) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_shift <= 8'h00;
    end else if (w_sym) begin
      if (testi3_e) begin
        // A start marker always begins a fresh byte, abandoning any partial one.
        r_shift <= {6'b0, testi2_e};
        r_cnt   <= 2'd1;
        r_state <= S_ASSEMBLE;
      end else if (r_state == S_ASSEMBLE) begin
        if (r_cnt == LAST_SYM) begin
          r_state <= S_IDLE;
          r_cnt   <= 2'd0;
          r_shift <= 8'h00;
        end else begin
          r_shift[{r_cnt, 1'b0} +: 2] <= testi2_e;
          r_cnt                       <= r_cnt + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge testi_clk_e) begin
    if (w_wr) r_mem[r_wr] <= w_push_byte;
  end

  always_ff @(posedge testi_clk_e or negedge testi_rst_n_e) begin
    if (!testi_rst_n_e) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_ferr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (!r_run) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_ferr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wr <= (r_wr == PTR_LAST) ? '0 : r_wr + PTR_W'(1);
      if (w_pop) r_rd <= (r_rd == PTR_LAST) ? '0 : r_rd + PTR_W'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      // Setting events take priority over a same-cycle clear.
      if (w_frm_err)      r_ferr <= 1'b1;
      else if (testi5_e)  r_ferr <= 1'b0;
      if (w_ovf)          r_ovf  <= 1'b1;
      else if (testi5_e)  r_ovf  <= 1'b0;
    end
  end

  assign testo1_e = ~w_empty;
  assign testo2_e = w_empty ? 8'h00 : r_mem[r_rd];
  assign testo3_e = r_ferr;
  assign testo4_e = r_level;
  assign testo5_e = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sub_e.sv
`default_nettype none
// Directed testbench for sub_e: reset, assembly, backpressure, framing, races.
module tb_sub_e;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v, st, rdy, clr;
  logic [1:0] d;
  logic       o1, o3, o5;
  logic [7:0] o2;
  logic [2:0] o4;
  int checks = 0;
  int errors = 0;

  sub_e #(.FIFO_DEPTH(4), .SYM_PER_BYTE(4)) dut (
    .testi_clk_e(clk), .testi_rst_n_e(rst_n),
    .testi1_e(v), .testi2_e(d), .testi3_e(st), .testi4_e(rdy), .testi5_e(clr),
    .testo1_e(o1), .testo2_e(o2), .testo3_e(o3), .testo4_e(o4), .testo5_e(o5)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic sym(input logic s_st, input logic [1:0] s_d);
    @(negedge clk); v = 1'b1; st = s_st; d = s_d;
  endtask

  task automatic idle();
    @(negedge clk); v = 1'b0; st = 1'b0; d = 2'b00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    sym(1'b1, b[1:0]); sym(1'b0, b[3:2]); sym(1'b0, b[5:4]); sym(1'b0, b[7:6]);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v = 0; st = 0; d = 0; rdy = 0; clr = 0;
    #12;
    checks++; if (o1 !== 1'b0)  begin errors++; $display("FAIL rst_o1 got %0b exp 0", o1); end
    checks++; if (o2 !== 8'h00) begin errors++; $display("FAIL rst_o2 got %h exp 00", o2); end
    checks++; if (o3 !== 1'b0)  begin errors++; $display("FAIL rst_o3 got %0b exp 0", o3); end
    checks++; if (o4 !== 3'd0)  begin errors++; $display("FAIL rst_o4 got %0d exp 0", o4); end
    checks++; if (o5 !== 1'b0)  begin errors++; $display("FAIL rst_o5 got %0b exp 0", o5); end
    // A stray symbol on the first edge after release must be ignored.
    @(negedge clk); rst_n = 1'b1; v = 1'b1; st = 1'b0; d = 2'b10;
    @(negedge clk); v = 1'b0;
    checks++; if (o3 !== 1'b0) begin errors++; $display("FAIL rst_edge1_ignored got %0b exp 0", o3); end
  endtask

  task automatic test_basic();
    rdy = 1'b1;
    sym(1'b1, 2'b01); sym(1'b0, 2'b10); sym(1'b0, 2'b11); sym(1'b0, 2'b00);
    idle();
    checks++; if (o1 !== 1'b1)  begin errors++; $display("FAIL basic_valid got %0b exp 1", o1); end
    checks++; if (o2 !== 8'h39) begin errors++; $display("FAIL basic_data got %h exp 39", o2); end
    checks++; if (o4 !== 3'd1)  begin errors++; $display("FAIL basic_level got %0d exp 1", o4); end
    @(negedge clk);
    checks++; if (o1 !== 1'b0)  begin errors++; $display("FAIL basic_popped got %0b exp 0", o1); end
    checks++; if (o4 !== 3'd0)  begin errors++; $display("FAIL basic_level0 got %0d exp 0", o4); end
    checks++; if (o2 !== 8'h00) begin errors++; $display("FAIL basic_empty_data got %h exp 00", o2); end
  endtask

  task automatic test_overflow();
    rdy = 1'b0;
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    idle();
    checks++; if (o4 !== 3'd4)  begin errors++; $display("FAIL ovf_level got %0d exp 4", o4); end
    checks++; if (o5 !== 1'b1)  begin errors++; $display("FAIL ovf_flag got %0b exp 1", o5); end
    @(negedge clk);
    checks++; if (o2 !== 8'h01) begin errors++; $display("FAIL ovf_stable got %h exp 01", o2); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (o2 !== 8'(i)) begin errors++; $display("FAIL ovf_drain%0d got %h exp %h", i, o2, 8'(i)); end
      rdy = 1'b1;
      @(negedge clk);
    end
    rdy = 1'b0;
    checks++; if (o1 !== 1'b0)  begin errors++; $display("FAIL ovf_lost5 got %0b exp 0", o1); end
    pulse_clr();
    checks++; if (o5 !== 1'b0)  begin errors++; $display("FAIL ovf_clear got %0b exp 0", o5); end
  endtask

  task automatic test_framing();
    rdy = 1'b1;
    sym(1'b0, 2'b10); idle();
    checks++; if (o3 !== 1'b1) begin errors++; $display("FAIL frm_idle_err got %0b exp 1", o3); end
    checks++; if (o4 !== 3'd0) begin errors++; $display("FAIL frm_no_push got %0d exp 0", o4); end
    pulse_clr();
    checks++; if (o3 !== 1'b0) begin errors++; $display("FAIL frm_clear1 got %0b exp 0", o3); end
    sym(1'b1, 2'b01); sym(1'b0, 2'b10);
    sym(1'b1, 2'b11); sym(1'b0, 2'b11); sym(1'b0, 2'b11); sym(1'b0, 2'b11);
    idle();
    checks++; if (o1 !== 1'b1)  begin errors++; $display("FAIL frm_valid got %0b exp 1", o1); end
    checks++; if (o2 !== 8'hFF) begin errors++; $display("FAIL frm_data got %h exp FF", o2); end
    checks++; if (o3 !== 1'b1)  begin errors++; $display("FAIL frm_restart_err got %0b exp 1", o3); end
    pulse_clr();
    checks++; if (o3 !== 1'b0)  begin errors++; $display("FAIL frm_clear2 got %0b exp 0", o3); end
    checks++; if (o1 !== 1'b0)  begin errors++; $display("FAIL frm_drained got %0b exp 0", o1); end
  endtask

  task automatic test_full_concurrent();
    logic [7:0] exp_q [4];
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
    rdy = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    sym(1'b1, 2'b01); sym(1'b0, 2'b01); sym(1'b0, 2'b01);
    @(negedge clk); v = 1'b1; st = 1'b0; d = 2'b01; rdy = 1'b1;
    @(negedge clk); v = 1'b0; rdy = 1'b0;
    checks++; if (o4 !== 3'd4)  begin errors++; $display("FAIL conc_level got %0d exp 4", o4); end
    checks++; if (o5 !== 1'b0)  begin errors++; $display("FAIL conc_no_ovf got %0b exp 0", o5); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (o2 !== exp_q[i]) begin errors++; $display("FAIL conc_order%0d got %h exp %h", i, o2, exp_q[i]); end
      rdy = 1'b1;
      @(negedge clk);
    end
    rdy = 1'b0;
    checks++; if (o4 !== 3'd0)  begin errors++; $display("FAIL conc_empty got %0d exp 0", o4); end
  endtask

  task automatic test_race();
    rdy = 1'b0;
    send_byte(8'h10); send_byte(8'h11); send_byte(8'h12); send_byte(8'h13);
    sym(1'b1, 2'b01); sym(1'b0, 2'b10); sym(1'b0, 2'b01);
    @(negedge clk); v = 1'b1; st = 1'b0; d = 2'b10; clr = 1'b1;
    @(negedge clk); v = 1'b0; clr = 1'b0;
    checks++; if (o5 !== 1'b1) begin errors++; $display("FAIL race_ovf_wins got %0b exp 1", o5); end
    checks++; if (o4 !== 3'd4) begin errors++; $display("FAIL race_level got %0d exp 4", o4); end
    rdy = 1'b1;
    repeat (5) @(negedge clk);
    rdy = 1'b0;
    pulse_clr();
    checks++; if (o5 !== 1'b0) begin errors++; $display("FAIL race_clear got %0b exp 0", o5); end
  endtask

  task automatic test_reset_mid();
    rdy = 1'b0;
    send_byte(8'h21); send_byte(8'h22); send_byte(8'h23);
    sym(1'b1, 2'b11); sym(1'b0, 2'b11);
    idle();
    checks++; if (o4 !== 3'd3) begin errors++; $display("FAIL mid_level got %0d exp 3", o4); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o1 !== 1'b0)  begin errors++; $display("FAIL mid_rst_o1 got %0b exp 0", o1); end
    checks++; if (o2 !== 8'h00) begin errors++; $display("FAIL mid_rst_o2 got %h exp 00", o2); end
    checks++; if (o4 !== 3'd0)  begin errors++; $display("FAIL mid_rst_o4 got %0d exp 0", o4); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk);
    rdy = 1'b1;
    send_byte(8'hA5);
    idle();
    checks++; if (o1 !== 1'b1)  begin errors++; $display("FAIL mid_new_valid got %0b exp 1", o1); end
    checks++; if (o2 !== 8'hA5) begin errors++; $display("FAIL mid_new_data got %h exp A5", o2); end
    checks++; if (o4 !== 3'd1)  begin errors++; $display("FAIL mid_new_level got %0d exp 1", o4); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_framing();
    test_full_concurrent();
    test_race();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
